// File: rtl/button_conditioner.sv
// Pushbutton conditioner: 2-flop synchroniser, per-button debounce FSM,
// single-cycle press/release pulses and optional auto-repeat pulses.
module button_conditioner #(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_EN       = 0,
    parameter int unsigned HOLD_CYCLES     = 50000000,
    parameter int unsigned REPEAT_CYCLES   = 10000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int unsigned MAX_DH  = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               RPT_ON    = (REPEAT_EN != 0);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    logic [N_BTN-1:0] meta_q;
    logic [N_BTN-1:0] sync_q;

    // Two-flop synchroniser; the only logic that looks at btn_raw.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_raw;
            sync_q <= meta_q;
        end
    end

    for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             rpt_phase_q, rpt_phase_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             release_q, release_d;
        logic             repeat_q, repeat_d;
        logic             sync;
        logic [CNT_W-1:0] rpt_last;

        assign sync     = sync_q[i];
        // rpt_phase selects the initial hold interval (0) or the repeat period (1).
        assign rpt_last = rpt_phase_q ? RPT_LAST : HOLD_LAST;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q     <= IDLE;
                cnt_q       <= CNT_ZERO;
                rpt_phase_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                release_q   <= 1'b0;
                repeat_q    <= 1'b0;
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                rpt_phase_q <= rpt_phase_d;
                level_q     <= level_d;
                press_q     <= press_d;
                release_q   <= release_d;
                repeat_q    <= repeat_d;
            end
        end

        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            rpt_phase_d = rpt_phase_q;
            level_d     = level_q;
            press_d     = 1'b0;
            release_d   = 1'b0;
            repeat_d    = 1'b0;

            unique case (state_q)
                IDLE: begin
                    level_d = 1'b0;
                    if (sync) begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync) begin
                        state_d = IDLE;
                        cnt_d   = CNT_ZERO;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d     = PRESSED;
                        level_d     = 1'b1;
                        press_d     = 1'b1;
                        cnt_d       = CNT_ZERO;
                        rpt_phase_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync) begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end else if (RPT_ON) begin
                        if (cnt_q == rpt_last) begin
                            repeat_d    = 1'b1;
                            cnt_d       = CNT_ZERO;
                            rpt_phase_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (sync) begin
                        // Bounce during release: back to held, repeat timing restarts.
                        state_d     = PRESSED;
                        cnt_d       = CNT_ZERO;
                        rpt_phase_d = 1'b0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d   = IDLE;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                        cnt_d     = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_repeat[i]  = repeat_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: DEBOUNCE=4, HOLD=8, REPEAT=3,
// with a second instance built with auto-repeat disabled.
module tb_button_conditioner;

    logic       clk;
    logic       reset;
    logic [2:0] btn_raw;
    logic [2:0] lev, prs, rel, rpt;
    logic [2:0] lev0, prs0, rel0, rpt0;

    int n_cmp;
    int n_err;

    button_conditioner #(
        .N_BTN(3), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .HOLD_CYCLES(8), .REPEAT_CYCLES(3)
    ) u_dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(lev), .btn_press(prs), .btn_release(rel), .btn_repeat(rpt)
    );

    button_conditioner #(
        .N_BTN(3), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .HOLD_CYCLES(8), .REPEAT_CYCLES(3)
    ) u_dut_norpt (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .btn_level(lev0), .btn_press(prs0), .btn_release(rel0), .btn_repeat(rpt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        btn_raw = 3'b000;
        tick();
        tick();
        n_cmp++; if (lev !== 3'b000) begin n_err++; $display("FAIL reset_level got %b exp 000", lev); end
        n_cmp++; if (prs !== 3'b000) begin n_err++; $display("FAIL reset_press got %b exp 000", prs); end
        n_cmp++; if (rel !== 3'b000) begin n_err++; $display("FAIL reset_release got %b exp 000", rel); end
        n_cmp++; if (rpt !== 3'b000) begin n_err++; $display("FAIL reset_repeat got %b exp 000", rpt); end
        reset = 1'b0;
        tick();
        tick();
        n_cmp++; if (lev !== 3'b000) begin n_err++; $display("FAIL post_reset_level got %b exp 000", lev); end
    endtask

    task automatic test_clean_press();
        logic [2:0] ep, el, er;
        btn_raw = 3'b001;
        for (int t = 1; t <= 20; t++) begin
            tick();
            ep = (t == 6) ? 3'b001 : 3'b000;
            el = (t >= 6) ? 3'b001 : 3'b000;
            n_cmp++; if (prs !== ep) begin n_err++; $display("FAIL clean_press t=%0d press got %b exp %b", t, prs, ep); end
            n_cmp++; if (lev !== el) begin n_err++; $display("FAIL clean_level t=%0d level got %b exp %b", t, lev, el); end
            n_cmp++; if (prs0 !== ep) begin n_err++; $display("FAIL clean_press_norpt t=%0d got %b exp %b", t, prs0, ep); end
            n_cmp++; if (lev0 !== el) begin n_err++; $display("FAIL clean_level_norpt t=%0d got %b exp %b", t, lev0, el); end
        end
        btn_raw = 3'b000;
        for (int t = 1; t <= 8; t++) begin
            tick();
            er = (t == 6) ? 3'b001 : 3'b000;
            el = (t < 6) ? 3'b001 : 3'b000;
            n_cmp++; if (rel !== er) begin n_err++; $display("FAIL clean_release t=%0d got %b exp %b", t, rel, er); end
            n_cmp++; if (lev !== el) begin n_err++; $display("FAIL clean_rel_level t=%0d got %b exp %b", t, lev, el); end
            n_cmp++; if (rel0 !== er) begin n_err++; $display("FAIL clean_release_norpt t=%0d got %b exp %b", t, rel0, er); end
            n_cmp++; if (prs !== 3'b000) begin n_err++; $display("FAIL clean_rel_press t=%0d got %b exp 000", t, prs); end
        end
    endtask

    task automatic test_bounce();
        logic [8:0] pat;
        pat = 9'b1_0110_1110;
        for (int i = 0; i < 19; i++) begin
            btn_raw = {1'b0, (i < 9) ? pat[8-i] : 1'b0, 1'b0};
            tick();
            n_cmp++; if ({lev, prs, rel} !== 9'b0) begin
                n_err++; $display("FAIL bounce i=%0d level/press/release got %b/%b/%b exp 000", i, lev, prs, rel);
            end
        end
    endtask

    task automatic test_auto_repeat();
        logic [2:0] ep, er, erp;
        btn_raw = 3'b100;
        for (int t = 1; t <= 44; t++) begin
            tick();
            ep  = (t == 6) ? 3'b100 : 3'b000;
            er  = (t == 42) ? 3'b100 : 3'b000;
            erp = (t >= 14 && t <= 38 && ((t - 14) % 3) == 0) ? 3'b100 : 3'b000;
            n_cmp++; if (rpt !== erp) begin n_err++; $display("FAIL auto_repeat t=%0d got %b exp %b", t, rpt, erp); end
            n_cmp++; if (rpt0 !== 3'b000) begin n_err++; $display("FAIL repeat_disabled t=%0d got %b exp 000", t, rpt0); end
            n_cmp++; if (prs !== ep) begin n_err++; $display("FAIL repeat_press t=%0d got %b exp %b", t, prs, ep); end
            n_cmp++; if (rel !== er) begin n_err++; $display("FAIL repeat_release t=%0d got %b exp %b", t, rel, er); end
            if (t == 36) btn_raw = 3'b000;
        end
    endtask

    task automatic test_release_bounce();
        logic [2:0] ep, er, el, erp;
        logic       hi;
        btn_raw = 3'b001;
        for (int t = 1; t <= 46; t++) begin
            tick();
            ep  = (t == 6) ? 3'b001 : 3'b000;
            er  = (t == 42) ? 3'b001 : 3'b000;
            el  = (t >= 6 && t < 42) ? 3'b001 : 3'b000;
            erp = (t == 14 || t == 17 || t == 29 || t == 32 || t == 35) ? 3'b001 : 3'b000;
            n_cmp++; if (prs !== ep) begin n_err++; $display("FAIL relb_press t=%0d got %b exp %b", t, prs, ep); end
            n_cmp++; if (rel !== er) begin n_err++; $display("FAIL relb_release t=%0d got %b exp %b", t, rel, er); end
            n_cmp++; if (lev !== el) begin n_err++; $display("FAIL relb_level t=%0d got %b exp %b", t, lev, el); end
            n_cmp++; if (rpt !== erp) begin n_err++; $display("FAIL relb_repeat t=%0d got %b exp %b", t, rpt, erp); end
            hi = (t <= 15) || (t >= 18 && t <= 32) || (t == 35);
            btn_raw = {2'b00, hi};
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ep, er, el;
        btn_raw = 3'b111;
        for (int t = 1; t <= 18; t++) begin
            tick();
            ep = (t == 6) ? 3'b111 : 3'b000;
            er = (t == 16) ? 3'b111 : 3'b000;
            el = (t >= 6 && t < 16) ? 3'b111 : 3'b000;
            n_cmp++; if (prs !== ep) begin n_err++; $display("FAIL simul_press t=%0d got %b exp %b", t, prs, ep); end
            n_cmp++; if (lev !== el) begin n_err++; $display("FAIL simul_level t=%0d got %b exp %b", t, lev, el); end
            n_cmp++; if (rel !== er) begin n_err++; $display("FAIL simul_release t=%0d got %b exp %b", t, rel, er); end
            n_cmp++; if (rpt !== 3'b000) begin n_err++; $display("FAIL simul_repeat t=%0d got %b exp 000", t, rpt); end
            if (t == 10) btn_raw = 3'b000;
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] ep, el, er;
        // Abort during PRESS_WAIT.
        btn_raw = 3'b010;
        for (int t = 1; t <= 4; t++) tick();
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({lev, prs} !== 6'b0) begin n_err++; $display("FAIL rst_pw_async level/press got %b/%b exp 000", lev, prs); end
        tick();
        tick();
        n_cmp++; if (prs !== 3'b000) begin n_err++; $display("FAIL rst_pw_press got %b exp 000", prs); end
        reset = 1'b0;
        for (int u = 1; u <= 10; u++) begin
            tick();
            ep = (u == 6) ? 3'b010 : 3'b000;
            el = (u >= 6) ? 3'b010 : 3'b000;
            n_cmp++; if (prs !== ep) begin n_err++; $display("FAIL rst_pw_repress u=%0d got %b exp %b", u, prs, ep); end
            n_cmp++; if (lev !== el) begin n_err++; $display("FAIL rst_pw_level u=%0d got %b exp %b", u, lev, el); end
        end
        // Abort during PRESSED: level must drop without waiting for a clock.
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (lev !== 3'b000) begin n_err++; $display("FAIL rst_pressed_async level got %b exp 000", lev); end
        for (int u = 1; u <= 2; u++) begin
            tick();
            n_cmp++; if ({lev, rel} !== 6'b0) begin n_err++; $display("FAIL rst_pressed_hold u=%0d level/release got %b/%b exp 000", u, lev, rel); end
        end
        reset = 1'b0;
        for (int u = 1; u <= 8; u++) begin
            tick();
            ep = (u == 6) ? 3'b010 : 3'b000;
            el = (u >= 6) ? 3'b010 : 3'b000;
            n_cmp++; if (prs !== ep) begin n_err++; $display("FAIL rst_repress u=%0d got %b exp %b", u, prs, ep); end
            n_cmp++; if (lev !== el) begin n_err++; $display("FAIL rst_repress_level u=%0d got %b exp %b", u, lev, el); end
            n_cmp++; if (rel !== 3'b000) begin n_err++; $display("FAIL rst_no_release u=%0d got %b exp 000", u, rel); end
        end
        btn_raw = 3'b000;
        for (int u = 1; u <= 8; u++) begin
            tick();
            er = (u == 6) ? 3'b010 : 3'b000;
            n_cmp++; if (rel !== er) begin n_err++; $display("FAIL rst_final_release u=%0d got %b exp %b", u, rel, er); end
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        btn_raw = 3'b000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_bounce();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input-side counterpart to the seven-segment output path. Takes raw, asynchronous, bouncing pushbutton levels (left/up/down) and makes them clean for the calculator control logic.
- Outputs per button: a debounced level, single-cycle press and release pulses, and optional auto-repeat pulses.
- Sits between the board buttons and the state selector, number-system select and operand-entry logic; all its outputs are synchronous to clk.

Parameters:
- N_BTN, 3, number of independent buttons conditioned.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a press or release (10 ms at 100 MHz); must be >= 2.
- REPEAT_EN, 0, 1 enables auto-repeat pulses while a button is held.
- HOLD_CYCLES, 50000000, cycles in PRESSED before the first repeat pulse; must be >= 1.
- REPEAT_CYCLES, 10000000, cycles between subsequent repeat pulses; must be >= 1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_raw  input  N_BTN  raw button levels, asynchronous to clk, active-high
- btn_level  output  N_BTN  debounced button level
- btn_press  output  N_BTN  one-cycle pulse on an accepted press
- btn_release  output  N_BTN  one-cycle pulse on an accepted release
- btn_repeat  output  N_BTN  one-cycle auto-repeat pulse; tied 0 when REPEAT_EN=0

Behaviour:
- Reset:
  - Asynchronous, active-high: all outputs, synchronisers, counters and FSMs clear immediately (outputs 0, FSM IDLE).
  - Reset asserted mid-debounce or mid-hold aborts that operation with no pulse emitted.
  - A button still held when reset deasserts must complete a full debounce and then produce a normal press pulse.
- Synchroniser:
  - Per bit, a 2-flop synchroniser reset to 0. sync[i] lags btn_raw[i] by 2 cycles.
  - Nothing downstream samples btn_raw directly.
- Independence:
  - Each button has its own FSM and counter. Buttons never interact; several press/release/repeat pulses may assert in the same cycle.
- Counter:
  - One per button, width $clog2(max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)+1).
  - Never wraps: it is always cleared before it reaches its terminal value.
- FSM states (per button): IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE (level 0):
    - sync=1 -> PRESS_WAIT, cnt=1.
    - Otherwise stay.
  - PRESS_WAIT (level 0):
    - sync=0 -> IDLE (bounce rejected, no pulse).
    - sync=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, level=1, press=1 for that one cycle, cnt=0.
    - Otherwise cnt++.
  - PRESSED (level 1):
    - sync=0 -> RELEASE_WAIT, cnt=1.
    - If REPEAT_EN=1 and sync=1: the first repeat pulse fires HOLD_CYCLES cycles after the press-pulse cycle, then every REPEAT_CYCLES cycles, for as long as sync=1.
  - RELEASE_WAIT (level 1):
    - sync=1 -> PRESSED. No press pulse. Repeat timing restarts as if freshly pressed (next repeat HOLD_CYCLES later).
    - sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, level=0, release=1 for that one cycle.
    - Otherwise cnt++.
- Latency:
  - btn_raw held high continuously from the first cycle it is sampled high: btn_press and btn_level rise DEBOUNCE_CYCLES+2 cycles later.
  - Release is symmetric.
- Pulse rules:
  - press, release and repeat are registered outputs, high exactly one cycle.
  - repeat never coincides with press or release.
  - level changes in the same cycle as the corresponding press/release pulse.
- Glitches: a pulse on btn_raw shorter than DEBOUNCE_CYCLES cycles, in either level, produces no output change.

Test Plan:
All scenarios use N_BTN=3, DEBOUNCE_CYCLES=4, HOLD_CYCLES=8, REPEAT_CYCLES=3, REPEAT_EN=1 unless stated.
1. Clean press: btn_raw[0] 0->1 held 20 cycles -> btn_press[0] high exactly one cycle, 6 cycles after the first high sample; btn_level[0]=1 from that cycle; bits 1 and 2 stay 0.
2. Bounce rejection: btn_raw[1] toggles 1,0,1,1,0,1,1,1,0 per cycle, then held 0 -> no press, level or release activity on bit 1.
3. Auto-repeat: btn_raw[2] held 30 cycles after its press pulse at cycle P -> repeat pulses at P+8, P+11, P+14, ...; REPEAT_EN=0 rerun -> btn_repeat stays 0.
4. Release with bounce: while pressed, btn_raw[0] goes 0 for 2 cycles, 1 for 1 cycle, then 0 held -> no release for the short dip; a single btn_release[0] pulse and level fall 6 cycles after the final falling sample; repeat timing restarted at the re-press.
5. Simultaneous: all three btn_raw rise on the same edge -> btn_press=3'b111 in one cycle, then btn_level=3'b111.
6. Reset mid-operation: assert reset during PRESS_WAIT and again during PRESSED with the button held -> outputs drop to 0 asynchronously with no release pulse; after deassert, a new press pulse arrives 6 cycles after the first synchronised sample.
